// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encodings and id width helper.
package arb_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'b00;
  localparam logic [1:0] ARB_GRANT   = 2'b01;
  localparam logic [1:0] ARB_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = ARB_IDLE,
    S_GRANT   = ARB_GRANT,
    S_RELEASE = ARB_RELEASE
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ARB_ID_W_DEFAULT = id_width(4);

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first asserted request at or after ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = int'(id_width(N_REQ))
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] cand;

  // Index base+off reduced modulo N_REQ; base is always below N_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[ID_W-1:0];
  endfunction

  // Walk the requesters in priority order starting at ptr and keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = wrap_add(ptr, i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter granting one requester at a time with a bounded hold time.
module rr_arbiter_fsm
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ-1:0]                done,
  output logic [N_REQ-1:0]                grant,
  output logic [id_width(N_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            timeout
);

  localparam int ID_W  = int'(id_width(N_REQ));
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_flag_q, timeout_flag_d;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  owner_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_next = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

  // Register state, owner, priority pointer, tenure counter and timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      ptr_q          <= '0;
      hold_cnt_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  // Next-state logic: pick in IDLE, release on done/drop before the hold limit, always recover to IDLE.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    hold_cnt_d     = hold_cnt_q;
    timeout_flag_d = timeout_flag_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d        = pick_idx;
          hold_cnt_d     = '0;
          timeout_flag_d = 1'b0;
          state_d        = S_GRANT;
        end
      end
      S_GRANT: begin
        if (done[owner_q] || !req[owner_q]) begin
          state_d        = S_RELEASE;
          timeout_flag_d = 1'b0;
          ptr_d          = owner_next;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d        = S_RELEASE;
          timeout_flag_d = 1'b1;
          ptr_d          = owner_next;
        end else begin
          hold_cnt_d     = hold_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        state_d        = S_IDLE;
        timeout_flag_d = 1'b0;
      end
      default: begin
        state_d        = S_IDLE;
        timeout_flag_d = 1'b0;
      end
    endcase
  end

  // Moore output decode from registered state and latched owner only.
  always_comb begin
    grant   = '0;
    busy    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_GRANT: begin
        grant[owner_q] = 1'b1;
        busy           = 1'b1;
      end
      S_RELEASE: timeout = timeout_flag_q;
      default: ;
    endcase
  end

  assign grant_id = owner_q;

endmodule
